// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the cache-to-memory arbiter.
package tcore_param;

  localparam int ARB_XLEN     = 32;
  localparam int ARB_BLK_SIZE = 128;
  localparam int ARB_TIMEOUT  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                    rw;
    logic [ARB_XLEN-1:0]     addr;
    logic [ARB_BLK_SIZE-1:0] data;
    logic                    uncached;
  } arb_req_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way priority picker: a lone requester wins, a tie goes to prio.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant
);

  // One-hot grant; bit 0 is the icache, bit 1 the dcache.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-wide memory port between the icache and dcache miss
// ports. One transaction at a time; the grant is held until the response
// (or a watchdog abort) and the response is steered back to the owner.
module mem_arbiter
  import tcore_param::*;
#(
  parameter int XLEN     = ARB_XLEN,
  parameter int BLK_SIZE = ARB_BLK_SIZE,
  parameter int TIMEOUT  = ARB_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ic_req_valid_i,
  input  logic [XLEN-1:0]     ic_req_addr_i,
  input  logic                ic_req_uncached_i,
  output logic                ic_res_valid_o,
  output logic [BLK_SIZE-1:0] ic_res_blk_o,
  input  logic                dc_req_valid_i,
  input  logic                dc_req_rw_i,
  input  logic [XLEN-1:0]     dc_req_addr_i,
  input  logic [BLK_SIZE-1:0] dc_req_data_i,
  input  logic                dc_req_uncached_i,
  output logic                dc_res_valid_o,
  output logic [BLK_SIZE-1:0] dc_res_blk_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic                mem_req_rw_o,
  output logic [XLEN-1:0]     mem_req_addr_o,
  output logic [BLK_SIZE-1:0] mem_req_data_o,
  output logic                mem_req_uncached_o,
  input  logic                mem_res_valid_i,
  input  logic [BLK_SIZE-1:0] mem_res_blk_i,
  output logic                err_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e          state;
  logic                owner;   // 0 = icache, 1 = dcache
  logic                prio;    // winner of a simultaneous request
  logic [CNT_W-1:0]    wd_cnt;
  logic [1:0]          grant;
  logic                res_hit;
  logic                res_timeout;
  logic                res_fire;
  logic [BLK_SIZE-1:0] res_blk;

  rr_arbiter2 u_rr (
    .req   ({dc_req_valid_i, ic_req_valid_i}),
    .prio  (prio),
    .grant (grant)
  );

  // Response steering: a real response wins over a same-cycle timeout.
  always_comb begin
    res_hit        = (state == ST_WAIT) && mem_res_valid_i;
    res_timeout    = (state == ST_WAIT) && !mem_res_valid_i && (wd_cnt == CNT_LAST);
    res_fire       = res_hit || res_timeout;
    res_blk        = res_hit ? mem_res_blk_i : '0;
    ic_res_valid_o = res_fire && !owner;
    dc_res_valid_o = res_fire && owner;
    ic_res_blk_o   = (res_fire && !owner) ? res_blk : '0;
    dc_res_blk_o   = (res_fire && owner) ? res_blk : '0;
  end

  // Arbitration FSM, latched request registers and the watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state              <= ST_IDLE;
      owner              <= 1'b0;
      prio               <= 1'b0;
      wd_cnt             <= '0;
      err_o              <= 1'b0;
      mem_req_valid_o    <= 1'b0;
      mem_req_rw_o       <= 1'b0;
      mem_req_addr_o     <= '0;
      mem_req_data_o     <= '0;
      mem_req_uncached_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wd_cnt <= '0;
          if (grant[0]) begin
            owner              <= 1'b0;
            mem_req_rw_o       <= 1'b0;
            mem_req_addr_o     <= ic_req_addr_i;
            mem_req_data_o     <= '0;
            mem_req_uncached_o <= ic_req_uncached_i;
            mem_req_valid_o    <= 1'b1;
            state              <= ST_ISSUE;
          end else if (grant[1]) begin
            owner              <= 1'b1;
            mem_req_rw_o       <= dc_req_rw_i;
            mem_req_addr_o     <= dc_req_addr_i;
            mem_req_data_o     <= dc_req_data_i;
            mem_req_uncached_o <= dc_req_uncached_i;
            mem_req_valid_o    <= 1'b1;
            state              <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            wd_cnt          <= '0;
            state           <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_res_valid_i) begin
            prio   <= ~owner;
            wd_cnt <= '0;
            state  <= ST_IDLE;
          end else if (wd_cnt == CNT_LAST) begin
            err_o  <= 1'b1;
            prio   <= ~prio;
            wd_cnt <= '0;
            state  <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        default: begin
          mem_req_valid_o <= 1'b0;
          wd_cnt          <= '0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
